// File: rtl/spm_pkg.sv
// spm_pkg -- shared types and helpers for the serial-parallel multiplier.
//   state_t   : controller states IDLE / RUN / DONE
//   cnt_width : bit width of the RUN cycle counter for a given operand width
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter spans 0..2*width-1; one extra bit of headroom so the terminal
  // compare never depends on a wrap.
  function automatic int cnt_width(input int width);
    return $clog2(2 * width) + 1;
  endfunction

endpackage

// File: rtl/spm_csa.sv
// spm_csa -- one registered carry-save cell of the serial-parallel multiplier.
//   Adds (i_a & i_x) to the sum arriving from the next-higher cell and to its
//   own stored carry; the sum and carry are registered.
//   Parameter NEG inverts the partial-product bit (negative-weight MSB cell
//   in two's-complement mode).
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   i_clr      synchronous clear of sum/carry (start of a new operation)
//   i_en       advance one serial step
//   i_a        parallel multiplicand bit for this cell
//   i_x        current serial multiplier bit
//   i_sum      registered sum of the next-higher cell (or top injection)
//   o_sum      registered sum of this cell
module spm_csa #(
  parameter bit NEG = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_a,
  input  logic i_x,
  input  logic i_sum,
  output logic o_sum
);

  logic r_sum, r_carry;
  logic w_t, w_s, w_c;

  assign w_t = (i_a & i_x) ^ NEG;
  assign w_s = w_t ^ i_sum ^ r_carry;
  assign w_c = (w_t & i_sum) | (w_t & r_carry) | (i_sum & r_carry);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum   <= 1'b0;
      r_carry <= 1'b0;
    end else if (i_clr) begin
      r_sum   <= 1'b0;
      r_carry <= 1'b0;
    end else if (i_en) begin
      r_sum   <= w_s;
      r_carry <= w_c;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/spm_gen.sv
// spm_gen -- serial-parallel (carry-save) multiplier, p = a*b mod 2^(2*WIDTH).
//   a is held in parallel across WIDTH carry-save cells; b is fed LSB-first,
//   one bit per cycle, for 2*WIDTH cycles. Each cycle cell 0 retires one
//   product bit. Result presented with a valid/ready handshake.
//   Optional macro SPM_SIGNED_EN: two's-complement operands (b sign-extended
//   serially, MSB cell negative-weight). Timing identical in both builds.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b)
//   out_valid / out_ready product handshake (p)
//   busy                  serial multiply in progress
module spm_gen
  import spm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  TERM = CW'(2 * WIDTH - 1);
`ifdef SPM_SIGNED_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [2*WIDTH-2:0] r_p;          // bits already retired from cell 0
  logic               r_busy, r_out_valid;

  logic               w_acc, w_run, w_top_in, w_fill;
  logic [WIDTH-1:0]   w_sum;

  assign in_ready = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign w_acc    = in_valid & in_ready;
  assign w_run    = (r_state == RUN);

  // Signed mode: the inverted MSB partial product adds 2^(WIDTH-1) every
  // cycle; one extra 2^(WIDTH-1) injected on the first step makes the total
  // bias a multiple of 2^(2*WIDTH), so it vanishes from the result.
  assign w_top_in = SIGNED_MODE & (r_cnt == '0);
  // Serial bits beyond WIDTH: zero, or the sign of b in signed mode.
  assign w_fill   = SIGNED_MODE & r_b[WIDTH-1];

  for (genvar j = 0; j < WIDTH; j++) begin : g_cell
    logic w_sin;
    if (j == WIDTH - 1) begin : g_top
      assign w_sin = w_top_in;
    end else begin : g_mid
      assign w_sin = w_sum[j+1];
    end
    spm_csa #(.NEG(SIGNED_MODE && (j == WIDTH - 1))) u_csa (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_acc),
      .i_en  (w_run),
      .i_a   (r_a[j]),
      .i_x   (r_b[0]),
      .i_sum (w_sin),
      .o_sum (w_sum[j])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_p         <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_acc) begin
      // Covers both IDLE accept and the DONE back-to-back handoff.
      r_state     <= RUN;
      r_cnt       <= '0;
      r_a         <= a;
      r_b         <= b;
      r_p         <= '0;
      r_busy      <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_b <= {w_fill, r_b[WIDTH-1:1]};
          // Cell 0 holds the newest product bit; shift the previous one out.
          r_p <= {w_sum[0], r_p[2*WIDTH-2:1]};
          if (r_cnt == TERM) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // After 2*WIDTH steps cell 0 holds the MSB and r_p the rest; both hold
  // still outside RUN, so p is stable while out_valid waits.
  assign p         = {w_sum[0], r_p};
  assign busy      = r_busy;
  assign out_valid = r_out_valid;

endmodule
